fetch_mem_if: RTL and testbench
===============================

FETCH_MEM_IF -- requirements
Module: fetch_mem_if

Interface
REQ-001 Parameters: DEPTH, 4, max in-flight plus buffered instruction words (power of two, ≥2); DEPTH_N, 2, log2(DEPTH).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 iCLOCK  in  1  clock, all state on rising edge.
REQ-004 iRESET_SYNC  in  1  synchronous active-high reset.
REQ-005 iFLUSH  in  1  exception flush; drop all pending and in-flight fetches.
REQ-006 iFETCH_REQ  in  1  fetch stage requests one word.
REQ-007 iFETCH_MMUMOD  in  2  MMU mode for the request.
REQ-008 iFETCH_ADDR  in  32  word address of the request.
REQ-009 oFETCH_LOCK  out  1  request not accepted this cycle.
REQ-010 oMEM_REQ / oMEM_MMUMOD / oMEM_ADDR  out  1/2/32  request to instruction memory.
REQ-011 iMEM_BUSY  in  1  memory cannot accept a request this cycle.
REQ-012 iMEM_VALID / iMEM_PAGEFAULT / iMEM_MMU_FLAGS / iMEM_DATA  in  1/1/14/32  in-order response.
REQ-013 oINST_VALID / oINST_PAGEFAULT / oINST_MMU_FLAGS / oINST  out  1/1/14/32  word to fetch stage.
REQ-014 iINST_LOCK  in  1  fetch stage holds; current output word stays and is not consumed.

Function
REQ-015 State: in-flight counter I, discard counter D (D ≤ I), buffer count F; credit I+F ranges 0..DEPTH.
REQ-016 oFETCH_LOCK = iMEM_BUSY || (I+F == DEPTH) || iFLUSH, combinational.
REQ-017 Accept = iFETCH_REQ && !oFETCH_LOCK; oMEM_REQ = accept; oMEM_ADDR/oMEM_MMUMOD pass through from fetch inputs, combinational.
REQ-018 Accept increments I; response (iMEM_VALID) decrements I; same-cycle accept and response leave I unchanged.
REQ-019 Response with D>0: D decrements, word dropped; with D==0: word pushed into buffer; credit guarantees buffer never overflows.
REQ-020 Pushed word appears on oINST* the cycle after iMEM_VALID (1-cycle latency); no combinational memory-to-fetch path.
REQ-021 oINST_VALID = (F>0) && !iFLUSH; oINST* show buffer head (first-word fall-through).
REQ-022 Pop when oINST_VALID && !iINST_LOCK; push and pop in the same cycle allowed, F unchanged.
REQ-023 Flush cycle: no accept; F cleared to 0; D <= I − iMEM_VALID; I <= I − iMEM_VALID; any response this cycle dropped.
REQ-024 Flush while D>0 recomputes D as in REQ-023 (all remaining in-flight become discards).
REQ-025 iMEM_VALID with I==0 is a protocol error: ignored, no counter underflow, no push.
REQ-026 Counters never wrap: I, F saturate within 0..DEPTH; buffer pointers wrap modulo DEPTH.

Reset
REQ-027 iRESET_SYNC high at a rising edge: I, D, F, pointers = 0; oINST_VALID, oINST_PAGEFAULT = 0; oINST_MMU_FLAGS, oINST = 0.
REQ-028 While reset high: oMEM_REQ = 0, oFETCH_LOCK = 1; responses ignored; reset mid-operation abandons in-flight words without discard tracking.

Structure
REQ-029 Shared package holds: MMU flags width 14, response entry width 47 ({pagefault, flags, data}), default DEPTH.
REQ-030 One sub-module inst_resp_fifo: DEPTH×47 fall-through FIFO, sync reset, single-cycle clear input, count output.

Verification
REQ-031 Back-to-back: REQ every cycle at 0x0,0x4,0x8,0xC, memory returns each 2 cycles later -> oINST words in order, each 1 cycle after its iMEM_VALID.
REQ-032 Credit full: DEPTH=4, iINST_LOCK=1, 4 requests accepted and returned -> oFETCH_LOCK=1, 5th request not issued; release lock one cycle -> one pop, lock drops next cycle.
REQ-033 Flush with 3 in flight, F=1 -> oINST_VALID=0 next cycle; next 3 responses dropped; request at 0x100 after flush returns first on oINST.
REQ-034 Flush coincident with iMEM_VALID, I=2 -> that word dropped, D=1, exactly one further response dropped.
REQ-035 iMEM_BUSY=1 with iFETCH_REQ=1 -> oMEM_REQ=0, oFETCH_LOCK=1, I unchanged.
REQ-036 Reset asserted with I=2, F=2 -> next cycle all outputs 0, late responses not pushed, first new request served normally.

Source files
------------

// File: rtl/fetch_mem_if_pkg.sv
// Shared definitions for the instruction fetch / memory interface slice.
//   MMU_FLAGS_W    width of the per-word MMU flag field
//   RESP_W         width of one buffered response entry {pagefault, flags, data}
//   DEFAULT_DEPTH  default credit depth (in-flight plus buffered words)
package fetch_mem_if_pkg;

  localparam int unsigned MMU_FLAGS_W     = 14;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned RESP_W          = 1 + MMU_FLAGS_W + DATA_W;
  localparam int unsigned DEFAULT_DEPTH   = 4;
  localparam int unsigned DEFAULT_DEPTH_N = 2;

  typedef struct packed {
    logic                   pagefault;
    logic [MMU_FLAGS_W-1:0] flags;
    logic [DATA_W-1:0]      data;
  } resp_t;

endpackage

// File: rtl/inst_resp_fifo.sv
// Fall-through FIFO holding instruction-memory responses for the fetch stage.
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   clear_i  single-cycle clear; drops all entries, ignores push/pop that cycle
//   push_i   write data_i (accepted when not full, or full with a pop)
//   pop_i    consume head entry (ignored when empty)
//   data_o   head entry, '0 when empty
//   count_o  number of stored entries (0..DEPTH)
module inst_resp_fifo
  import fetch_mem_if_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned DEPTH_N = DEFAULT_DEPTH_N
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  resp_t            data_i,
  input  logic             pop_i,
  output resp_t            data_o,
  output logic [DEPTH_N:0] count_o
);

  resp_t              mem_q [DEPTH];
  logic [DEPTH_N-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_N:0]   count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q < (DEPTH_N+1)'(DEPTH)) || do_pop);
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_mem_if.sv
// Credit-based bridge between the fetch stage and in-order instruction memory.
// Requests pass straight through to memory; responses are buffered one cycle
// in a fall-through FIFO. A flush turns every in-flight request into a
// discard so late responses are dropped.
//   iCLOCK / iRESET_SYNC                      clock, synchronous active-high reset
//   iFLUSH                                    drop pending and in-flight fetches
//   iFETCH_REQ/_MMUMOD/_ADDR, oFETCH_LOCK     fetch-side request, back-pressure
//   oMEM_REQ/_MMUMOD/_ADDR, iMEM_BUSY         memory-side request
//   iMEM_VALID/_PAGEFAULT/_MMU_FLAGS/_DATA    memory response (in order)
//   oINST_VALID/_PAGEFAULT/_MMU_FLAGS, oINST  buffered word to fetch stage
//   iINST_LOCK                                fetch stage holds current word
module fetch_mem_if
  import fetch_mem_if_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned DEPTH_N = DEFAULT_DEPTH_N
) (
  input  logic                   iCLOCK,
  input  logic                   iRESET_SYNC,
  input  logic                   iFLUSH,
  input  logic                   iFETCH_REQ,
  input  logic [1:0]             iFETCH_MMUMOD,
  input  logic [31:0]            iFETCH_ADDR,
  output logic                   oFETCH_LOCK,
  output logic                   oMEM_REQ,
  output logic [1:0]             oMEM_MMUMOD,
  output logic [31:0]            oMEM_ADDR,
  input  logic                   iMEM_BUSY,
  input  logic                   iMEM_VALID,
  input  logic                   iMEM_PAGEFAULT,
  input  logic [MMU_FLAGS_W-1:0] iMEM_MMU_FLAGS,
  input  logic [31:0]            iMEM_DATA,
  output logic                   oINST_VALID,
  output logic                   oINST_PAGEFAULT,
  output logic [MMU_FLAGS_W-1:0] oINST_MMU_FLAGS,
  output logic [31:0]            oINST,
  input  logic                   iINST_LOCK
);

  logic [DEPTH_N:0]   inflight_q, inflight_d;
  logic [DEPTH_N:0]   discard_q, discard_d;
  logic [DEPTH_N:0]   fifo_count;
  logic [DEPTH_N+1:0] credit;
  logic               accept, resp_ok, push, pop;
  resp_t              resp_in, head;

  assign credit = {1'b0, inflight_q} + {1'b0, fifo_count};

  assign oFETCH_LOCK = iRESET_SYNC || iMEM_BUSY || iFLUSH
                    || (credit >= (DEPTH_N+2)'(DEPTH));
  assign accept      = iFETCH_REQ && !oFETCH_LOCK;
  assign oMEM_REQ    = accept;
  assign oMEM_ADDR   = iFETCH_ADDR;
  assign oMEM_MMUMOD = iFETCH_MMUMOD;

  // A response with nothing in flight is a protocol error and is ignored.
  assign resp_ok = iMEM_VALID && (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    discard_d  = discard_q;
    push       = 1'b0;
    if (iFLUSH) begin
      // Everything still outstanding after this cycle becomes a discard.
      inflight_d = inflight_q - {{DEPTH_N{1'b0}}, resp_ok};
      discard_d  = inflight_q - {{DEPTH_N{1'b0}}, resp_ok};
    end else begin
      if (accept && !resp_ok && (inflight_q < (DEPTH_N+1)'(DEPTH))) begin
        inflight_d = inflight_q + 1'b1;
      end else if (!accept && resp_ok) begin
        inflight_d = inflight_q - 1'b1;
      end
      if (resp_ok) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else begin
          push = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  assign resp_in = '{pagefault: iMEM_PAGEFAULT, flags: iMEM_MMU_FLAGS, data: iMEM_DATA};

  assign oINST_VALID     = (fifo_count != '0) && !iFLUSH;
  assign pop             = oINST_VALID && !iINST_LOCK;
  assign oINST_PAGEFAULT = head.pagefault;
  assign oINST_MMU_FLAGS = head.flags;
  assign oINST           = head.data;

  inst_resp_fifo #(
    .DEPTH  (DEPTH),
    .DEPTH_N(DEPTH_N)
  ) u_fifo (
    .clk_i  (iCLOCK),
    .rst_i  (iRESET_SYNC),
    .clear_i(iFLUSH),
    .push_i (push),
    .data_i (resp_in),
    .pop_i  (pop),
    .data_o (head),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_fetch_mem_if.sv
module tb_fetch_mem_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  mmu = '0;
  logic [31:0] addr = '0;
  logic        lock_o;
  logic        mreq_o;
  logic [1:0]  mmmu_o;
  logic [31:0] maddr_o;
  logic        busy = 1'b0;
  logic        mvalid = 1'b0;
  logic        mpf = 1'b0;
  logic [13:0] mflags = '0;
  logic [31:0] mdata = '0;
  logic        ivalid_o;
  logic        ipf_o;
  logic [13:0] iflags_o;
  logic [31:0] inst_o;
  logic        ilock = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_mem_if #(.DEPTH(4), .DEPTH_N(2)) dut (
    .iCLOCK         (clk),
    .iRESET_SYNC    (rst),
    .iFLUSH         (flush),
    .iFETCH_REQ     (req),
    .iFETCH_MMUMOD  (mmu),
    .iFETCH_ADDR    (addr),
    .oFETCH_LOCK    (lock_o),
    .oMEM_REQ       (mreq_o),
    .oMEM_MMUMOD    (mmmu_o),
    .oMEM_ADDR      (maddr_o),
    .iMEM_BUSY      (busy),
    .iMEM_VALID     (mvalid),
    .iMEM_PAGEFAULT (mpf),
    .iMEM_MMU_FLAGS (mflags),
    .iMEM_DATA      (mdata),
    .oINST_VALID    (ivalid_o),
    .oINST_PAGEFAULT(ipf_o),
    .oINST_MMU_FLAGS(iflags_o),
    .oINST          (inst_o),
    .iINST_LOCK     (ilock)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    flush  = 1'b0;
    req    = 1'b0;
    busy   = 1'b0;
    mvalid = 1'b0;
    mpf    = 1'b0;
    mflags = '0;
    mdata  = '0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [1:0] m);
    req  = 1'b1;
    addr = a;
    mmu  = m;
  endtask

  task automatic resp(input logic [31:0] d, input logic pf, input logic [13:0] fl);
    mvalid = 1'b1;
    mdata  = d;
    mpf    = pf;
    mflags = fl;
  endtask

  initial begin
    // ---------------- reset ----------------
    cyc(); rst = 1'b1; fetch(32'h0, 2'd0); #1;
    chk("rst_lock", 32'(lock_o), 32'd1);
    chk("rst_memreq", 32'(mreq_o), 32'd0);
    cyc(); #1;
    chk("rst_valid", 32'(ivalid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_flags", 32'(iflags_o), 32'd0);
    chk("rst_pf", 32'(ipf_o), 32'd0);
    chk("rst_idle_lock", 32'(lock_o), 32'd0);

    // ---------------- back-to-back ----------------
    cyc(); fetch(32'h0, 2'd2); #1;
    chk("b2b_req0", 32'(mreq_o), 32'd1);
    chk("b2b_addr0", maddr_o, 32'h0);
    chk("b2b_mmu0", 32'(mmmu_o), 32'd2);
    cyc(); fetch(32'h4, 2'd1); #1;
    chk("b2b_req1", 32'(mreq_o), 32'd1);
    chk("b2b_valid_before", 32'(ivalid_o), 32'd0);
    cyc(); fetch(32'h8, 2'd0); resp(32'hA000_0000, 1'b0, 14'h0011); #1;
    chk("b2b_req2", 32'(mreq_o), 32'd1);
    chk("b2b_no_comb_path", 32'(ivalid_o), 32'd0);
    cyc(); fetch(32'hC, 2'd0); resp(32'hA000_0001, 1'b1, 14'h1234); #1;
    chk("b2b_req3", 32'(mreq_o), 32'd1);
    chk("b2b_addr3", maddr_o, 32'hC);
    chk("b2b_w0_valid", 32'(ivalid_o), 32'd1);
    chk("b2b_w0", inst_o, 32'hA000_0000);
    chk("b2b_w0_flags", 32'(iflags_o), 32'h0011);
    cyc(); resp(32'hA000_0002, 1'b0, 14'h0); #1;
    chk("b2b_w1", inst_o, 32'hA000_0001);
    chk("b2b_w1_pf", 32'(ipf_o), 32'd1);
    chk("b2b_w1_flags", 32'(iflags_o), 32'h1234);
    cyc(); resp(32'hA000_0003, 1'b0, 14'h0); #1;
    chk("b2b_w2", inst_o, 32'hA000_0002);
    cyc(); #1;
    chk("b2b_w3", inst_o, 32'hA000_0003);
    chk("b2b_w3_pf", 32'(ipf_o), 32'd0);
    cyc(); #1;
    chk("b2b_empty", 32'(ivalid_o), 32'd0);

    // ---------------- memory busy ----------------
    cyc(); busy = 1'b1; fetch(32'h40, 2'd0); #1;
    chk("busy_memreq", 32'(mreq_o), 32'd0);
    chk("busy_lock", 32'(lock_o), 32'd1);
    cyc(); #1;
    chk("busy_release", 32'(lock_o), 32'd0);

    // ---------------- credit full ----------------
    ilock = 1'b1;
    cyc(); fetch(32'h10, 2'd0); #1; chk("cr_req0", 32'(mreq_o), 32'd1);
    cyc(); fetch(32'h14, 2'd0); #1; chk("cr_req1", 32'(mreq_o), 32'd1);
    cyc(); fetch(32'h18, 2'd0); #1; chk("cr_req2", 32'(mreq_o), 32'd1);
    cyc(); fetch(32'h1C, 2'd0); #1; chk("cr_req3", 32'(mreq_o), 32'd1);
    cyc(); fetch(32'h20, 2'd0); resp(32'hE000_0000, 1'b0, 14'h0); #1;
    chk("cr_lock_i4", 32'(lock_o), 32'd1);
    chk("cr_req4_blocked", 32'(mreq_o), 32'd0);
    cyc(); fetch(32'h20, 2'd0); resp(32'hE000_0001, 1'b0, 14'h0); #1;
    chk("cr_lock_a", 32'(lock_o), 32'd1);
    cyc(); fetch(32'h20, 2'd0); resp(32'hE000_0002, 1'b0, 14'h0); #1;
    chk("cr_lock_b", 32'(lock_o), 32'd1);
    cyc(); fetch(32'h20, 2'd0); resp(32'hE000_0003, 1'b0, 14'h0); #1;
    chk("cr_lock_c", 32'(lock_o), 32'd1);
    chk("cr_held_head", inst_o, 32'hE000_0000);
    cyc(); fetch(32'h20, 2'd0); #1;
    chk("cr_full_lock", 32'(lock_o), 32'd1);
    chk("cr_full_memreq", 32'(mreq_o), 32'd0);
    chk("cr_full_valid", 32'(ivalid_o), 32'd1);
    chk("cr_full_head", inst_o, 32'hE000_0000);
    cyc(); ilock = 1'b0; fetch(32'h20, 2'd0); #1;
    chk("cr_pop_lock", 32'(lock_o), 32'd1);
    chk("cr_pop_head", inst_o, 32'hE000_0000);
    cyc(); ilock = 1'b1; fetch(32'h20, 2'd3); #1;
    chk("cr_unlock", 32'(lock_o), 32'd0);
    chk("cr_req5", 32'(mreq_o), 32'd1);
    chk("cr_req5_addr", maddr_o, 32'h20);
    chk("cr_next_head", inst_o, 32'hE000_0001);
    cyc(); resp(32'hE000_0004, 1'b0, 14'h0); #1;
    chk("cr_refill_lock", 32'(lock_o), 32'd1);
    cyc(); ilock = 1'b0; #1; chk("cr_d1", inst_o, 32'hE000_0001);
    cyc(); #1; chk("cr_d2", inst_o, 32'hE000_0002);
    cyc(); #1; chk("cr_d3", inst_o, 32'hE000_0003);
    cyc(); #1; chk("cr_d4", inst_o, 32'hE000_0004);
    cyc(); #1; chk("cr_drained", 32'(ivalid_o), 32'd0);

    // ---------------- flush, 3 in flight, 1 buffered ----------------
    ilock = 1'b1;
    cyc(); fetch(32'h50, 2'd0); #1;
    cyc(); fetch(32'h54, 2'd0); #1;
    cyc(); fetch(32'h58, 2'd0); resp(32'hB000_0000, 1'b0, 14'h0); #1;
    cyc(); fetch(32'h5C, 2'd0); #1;
    chk("fl_pre_valid", 32'(ivalid_o), 32'd1);
    cyc(); flush = 1'b1; fetch(32'h60, 2'd0); #1;
    chk("fl_memreq", 32'(mreq_o), 32'd0);
    chk("fl_lock", 32'(lock_o), 32'd1);
    chk("fl_valid_during", 32'(ivalid_o), 32'd0);
    cyc(); ilock = 1'b0; fetch(32'h100, 2'd1); #1;
    chk("fl_valid_after", 32'(ivalid_o), 32'd0);
    chk("fl_new_req", 32'(mreq_o), 32'd1);
    chk("fl_new_addr", maddr_o, 32'h100);
    cyc(); resp(32'hDEAD_0001, 1'b0, 14'h0); #1;
    chk("fl_drop0", 32'(ivalid_o), 32'd0);
    cyc(); resp(32'hDEAD_0002, 1'b0, 14'h0); #1;
    chk("fl_drop1", 32'(ivalid_o), 32'd0);
    cyc(); resp(32'hDEAD_0003, 1'b0, 14'h0); #1;
    chk("fl_drop2", 32'(ivalid_o), 32'd0);
    cyc(); resp(32'h0000_0100, 1'b0, 14'h0A5); #1;
    chk("fl_drop3", 32'(ivalid_o), 32'd0);
    cyc(); #1;
    chk("fl_first_valid", 32'(ivalid_o), 32'd1);
    chk("fl_first_inst", inst_o, 32'h0000_0100);
    chk("fl_first_flags", 32'(iflags_o), 32'h00A5);
    cyc(); #1;
    chk("fl_empty", 32'(ivalid_o), 32'd0);

    // ---------------- flush coincident with a response, I=2 ----------------
    cyc(); fetch(32'h70, 2'd0); #1;
    cyc(); fetch(32'h74, 2'd0); #1;
    cyc(); flush = 1'b1; resp(32'hDEAD_0010, 1'b0, 14'h0); #1;
    cyc(); fetch(32'h200, 2'd0); #1;
    chk("fc_valid0", 32'(ivalid_o), 32'd0);
    chk("fc_new_req", 32'(mreq_o), 32'd1);
    cyc(); resp(32'hDEAD_0011, 1'b0, 14'h0); #1;
    chk("fc_valid1", 32'(ivalid_o), 32'd0);
    cyc(); resp(32'h0000_0200, 1'b0, 14'h0); #1;
    chk("fc_valid2", 32'(ivalid_o), 32'd0);
    cyc(); #1;
    chk("fc_good_valid", 32'(ivalid_o), 32'd1);
    chk("fc_good_inst", inst_o, 32'h0000_0200);
    cyc(); #1;
    chk("fc_empty", 32'(ivalid_o), 32'd0);

    // ---------------- stray response with nothing in flight ----------------
    cyc(); resp(32'hBAD0_0000, 1'b1, 14'h3FFF); #1;
    cyc(); #1;
    chk("stray_valid", 32'(ivalid_o), 32'd0);
    chk("stray_lock", 32'(lock_o), 32'd0);

    // ---------------- reset mid-operation, I=2 F=2 ----------------
    ilock = 1'b1;
    cyc(); fetch(32'h80, 2'd0); #1;
    cyc(); fetch(32'h84, 2'd0); #1;
    cyc(); fetch(32'h88, 2'd0); resp(32'hC000_0000, 1'b0, 14'h0); #1;
    cyc(); fetch(32'h8C, 2'd0); resp(32'hC000_0001, 1'b0, 14'h0); #1;
    chk("mr_pre_valid", 32'(ivalid_o), 32'd1);
    cyc(); rst = 1'b1; fetch(32'h90, 2'd0); #1;
    chk("mr_memreq", 32'(mreq_o), 32'd0);
    chk("mr_lock", 32'(lock_o), 32'd1);
    cyc(); resp(32'hDEAD_0020, 1'b1, 14'h0001); #1;
    chk("mr_valid", 32'(ivalid_o), 32'd0);
    chk("mr_inst", inst_o, 32'd0);
    chk("mr_pf", 32'(ipf_o), 32'd0);
    chk("mr_flags", 32'(iflags_o), 32'd0);
    cyc(); fetch(32'h300, 2'd0); resp(32'hDEAD_0021, 1'b0, 14'h0); #1;
    chk("mr_late_dropped", 32'(ivalid_o), 32'd0);
    chk("mr_new_req", 32'(mreq_o), 32'd1);
    cyc(); resp(32'h0000_0300, 1'b0, 14'h0); #1;
    chk("mr_pre_new", 32'(ivalid_o), 32'd0);
    cyc(); ilock = 1'b0; #1;
    chk("mr_new_valid", 32'(ivalid_o), 32'd1);
    chk("mr_new_inst", inst_o, 32'h0000_0300);
    cyc(); #1;
    chk("mr_empty", 32'(ivalid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
